// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

    localparam int IMEM_AW  = 10;
    localparam int PC_WIDTH = IMEM_AW + 2;
    // Canonical NOP (addi x0,x0,0). inst_data is masked to zero when the FIFO
    // is empty, so decode must qualify with inst_valid rather than expect a NOP.
    localparam logic [31:0] INST_NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; pointers carry an extra MSB to tell full from empty.
module fetch_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: PC register, fetch FSM and redirect handling in front of a prefetch FIFO.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               ADDR_WIDTH = IMEM_AW,
    parameter int               DATA_WIDTH = 32,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH+1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fetch_en,
    input  logic                          redirect_valid,
    input  logic [ADDR_WIDTH+1:0]         redirect_pc,
    output logic [ADDR_WIDTH-1:0]         imem_addr,
    input  logic [DATA_WIDTH-1:0]         imem_rdata,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [DATA_WIDTH-1:0]         inst_data,
    output logic [ADDR_WIDTH+1:0]         inst_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PC_W = ADDR_WIDTH + 2;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    state_t                     state, state_nxt;
    logic [PC_W-1:0]            pc;
    logic                       push, pop, full, empty;
    logic [CW-1:0]              count_nxt;
    logic [DATA_WIDTH+PC_W-1:0] head;

    assign imem_addr  = pc[PC_W-1:2];
    assign inst_valid = !empty;
    assign pop        = inst_valid && inst_ready;
    // fetch_en gates the push directly so dropping it holds the PC on the very next edge.
    assign push       = fetch_en && !redirect_valid &&
                        ((state == FETCH) || (state == FULL && pop));
    assign inst_data  = empty ? '0 : head[DATA_WIDTH+PC_W-1:PC_W];
    assign inst_pc    = empty ? '0 : head[PC_W-1:0];

    fetch_fifo #(.WIDTH(DATA_WIDTH + PC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({imem_rdata, pc}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_comb begin
        count_nxt = fifo_count + CW'(push) - CW'(pop);
        if (redirect_valid) count_nxt = '0;
        state_nxt = FETCH;
        if (!fetch_en)                             state_nxt = IDLE;
        else if (count_nxt == CW'(FIFO_DEPTH))     state_nxt = FULL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect_valid) pc <= redirect_pc & ~PC_W'(3);
            else if (push)      pc <= pc + PC_W'(4);
        end
    end

    logic unused_full;
    assign unused_full = full;
endmodule
